// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// dmem_responder: fixed-latency valid/ready slave for the data-memory port.
// Revision: 1.0
// ============================================================================
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] index;
  logic                  addr_err;
  logic                  do_access;
  logic                  mem_we;

  // Decode from the latched request so a changing bus after acceptance is harmless.
  assign index     = addr_q[ADDR_WIDTH+1:2];
  assign addr_err  = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
  assign do_access = (state_q == S_WAIT) && (count_q == 4'd0);
  assign mem_we    = do_access && write_q && !addr_err && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage has no reset; stores commit only on the WAIT->RESP edge.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[index] <= wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          count_d = CNT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (count_q == 4'd0) begin
          err_d   = addr_err;
          rdata_d = (write_q || addr_err) ? 32'd0 : mem[index];
          state_d = S_RESP;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      S_RESP: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_valid = (state_q == S_RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// tb_dmem_responder: scoreboard bench over three responders (LATENCY 2, 1 and 15).
module tb_dmem_responder;

  localparam int N_DUT = 3;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid  [N_DUT];
  logic        req_write  [N_DUT];
  logic [31:0] req_addr   [N_DUT];
  logic [31:0] req_wdata  [N_DUT];
  logic        req_ready  [N_DUT];
  logic        resp_valid [N_DUT];
  logic [31:0] resp_rdata [N_DUT];
  logic        resp_err   [N_DUT];

  exp_t sb[$];
  vec_t vecs[10];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    dmem_responder #(
      .ADDR_WIDTH(10),
      .LATENCY   (gi == 0 ? 2 : (gi == 1 ? 1 : 15))
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid[gi]),
      .req_write (req_write[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_ready (req_ready[gi]),
      .resp_valid(resp_valid[gi]),
      .resp_rdata(resp_rdata[gi]),
      .resp_err  (resp_err[gi])
    );
  end

  always #5 clock = ~clock;

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 15);
  endfunction

  function automatic bit has_entries(input int i);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].inst == i) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, inst, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string name, input int inst);
    n_cmp++;
    n_fail++;
    $display("FAIL %s dut%0d: got timeout/unexpected expected event (cycle %0d)", name, inst, cyc);
  endtask

  // Per-cycle observer: latency, handshake, response payload and idle-zero checks.
  always @(negedge clock) begin
    int   head;
    int   pend;
    bit   exp_v;
    exp_t tmp;
    cyc++;
    if (mon_en) begin
      for (int i = 0; i < N_DUT; i++) begin
        head = -1;
        pend = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (head < 0 && sb[k].inst == i && sb[k].due >= 0) head = k;
          if (pend < 0 && sb[k].inst == i && sb[k].due < 0) pend = k;
        end
        exp_v = 1'b0;
        if (head >= 0) exp_v = (sb[head].due == cyc);
        check("req_ready", i, 32'(req_ready[i]), 32'(head < 0));
        check("resp_valid", i, 32'(resp_valid[i]), 32'(exp_v));
        if (resp_valid[i] && head >= 0) begin
          check("resp_rdata", i, resp_rdata[i], sb[head].rdata);
          check("resp_err", i, 32'(resp_err[i]), 32'(sb[head].err));
          sb.delete(head);
          if (pend > head) pend--;
        end else if (!resp_valid[i]) begin
          check("idle_rdata", i, resp_rdata[i], 32'd0);
          check("idle_err", i, 32'(resp_err[i]), 32'd0);
        end
        if (!reset && req_valid[i] && req_ready[i]) begin
          if (pend < 0) begin
            fail_msg("unexpected_accept", i);
          end else begin
            tmp      = sb[pend];
            tmp.due  = cyc + lat_of(i) + 1;
            sb[pend] = tmp;
          end
        end
      end
      if (reset) sb.delete();
    end
  end

  // Caller is positioned just after a rising edge.
  task automatic send(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
    exp_t e;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[i]  = a;
    req_wdata[i] = d;
    e.inst  = i;
    e.rdata = er;
    e.err   = ee;
    e.due   = -1;
    sb.push_back(e);
  endtask

  task automatic wait_accept(input int i, output time t_acc);
    int t = 0;
    @(negedge clock);
    while (!req_ready[i] && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (!req_ready[i]) fail_msg("accept_timeout", i);
    t_acc = $time;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (has_entries(i) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (has_entries(i)) fail_msg("resp_timeout", i);
    @(posedge clock);
    #1;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    time ta;
    send(i, v.write, v.addr, v.wdata, v.rdata, v.err);
    wait_accept(i, ta);
    req_valid[i] = 1'b0;
    wait_idle(i);
  endtask

  // req_valid held high; even slots store, odd slots read the word just stored.
  task automatic stream(input int i, input int n);
    logic [31:0] d;
    logic [31:0] last_d;
    time         ta;
    time         prev_ta;
    last_d  = 32'd0;
    prev_ta = 0;
    for (int j = 0; j < n; j++) begin
      d = 32'hA500_0000 ^ (32'(j) * 32'h0101_0101) ^ 32'(i);
      if (j % 2 == 0) begin
        send(i, 1'b1, 32'h100 + 32'(4 * j), d, 32'd0, 1'b0);
        last_d = d;
      end else begin
        send(i, 1'b0, 32'h100 + 32'(4 * (j - 1)), 32'hFFFF_FFFF, last_d, 1'b0);
      end
      wait_accept(i, ta);
      if (j > 0) check("accept_spacing", i, 32'((ta - prev_ta) / 10), 32'(lat_of(i) + 2));
      prev_ta = ta;
    end
    req_valid[i] = 1'b0;
    wait_idle(i);
  endtask

  initial begin
    time ta;
    int  t;
    for (int i = 0; i < N_DUT; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
    end
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0013, 32'h5555_AAAA, 32'h0000_0000, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[7] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[8] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[9] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1};

    repeat (3) @(posedge clock);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (5) @(posedge clock);
    #1;

    for (int v = 0; v < 10; v++) run_vec(0, vecs[v]);

    // Reset while in WAIT discards the pending store.
    send(0, 1'b1, 32'h20, 32'h1234_5678, 32'd0, 1'b0);
    wait_accept(0, ta);
    req_valid[0] = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_vec(0, '{1'b0, 32'h20, 32'h0, 32'h0BAD_F00D, 1'b0});

    // Reset while in RESP: the store has already committed.
    send(0, 1'b1, 32'h24, 32'h1111_2222, 32'd0, 1'b0);
    wait_accept(0, ta);
    req_valid[0] = 1'b0;
    t = 0;
    @(negedge clock);
    while (!resp_valid[0] && t < 50) begin
      @(negedge clock);
      t++;
    end
    if (!resp_valid[0]) fail_msg("resp_timeout_resp_reset", 0);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_vec(0, '{1'b0, 32'h24, 32'h0, 32'h1111_2222, 1'b0});

    fork
      stream(1, 8);
      stream(2, 8);
    join

    repeat (3) @(posedge clock);
    #1;
    check("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
